// File: rtl/wb_regfile_pkg.sv
// Shared writeback-stage constants: WB_in bit positions, default widths,
// and the hard-wired zero register index.
package wb_regfile_pkg;
  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int ZERO_REG    = 0;
endpackage

// File: rtl/wb_regfile_regfile_array.sv
// Flip-flop register storage: one write port, two raw asynchronous read ports.
// Register 0 is never written and always reads as zero.
module regfile_array
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [NREGS-1:0][DATA_W-1:0] regs;

  always_ff @(posedge clk) begin
    if (reset)
      regs <= '0;
    else if (we && waddr != ZERO_IDX)
      regs[waddr] <= wdata;
  end

  // Zero-index reads are gated so the slot's contents never matter.
  assign rdata1 = (raddr1 == ZERO_IDX) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == ZERO_IDX) ? '0 : regs[raddr2];
endmodule

// File: rtl/wb_regfile.sv
// Writeback stage register file: result mux, write-before-read bypass on both
// read ports, and a retired-write counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        WB_in,
  input  logic [DATA_W-1:0] DatoLeido,
  input  logic [DATA_W-1:0] Direccion,
  input  logic [ADDR_W-1:0] MUXRes,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] Dato1,
  output logic [DATA_W-1:0] Dato2,
  output logic [DATA_W-1:0] WriteData,
  output logic [31:0]       RetireCount
);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic              commit;
  logic [DATA_W-1:0] raw1, raw2;
  logic [31:0]       retire_count_q;

  assign WriteData = WB_in[WB_MEMTOREG] ? DatoLeido : Direccion;
  assign commit    = WB_in[WB_REGWRITE] && (MUXRes != ZERO_IDX);

  regfile_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
    .clk    (clk),
    .reset  (reset),
    .we     (commit),
    .waddr  (MUXRes),
    .wdata  (WriteData),
    .raddr1 (ReadReg1),
    .raddr2 (ReadReg2),
    .rdata1 (raw1),
    .rdata2 (raw2)
  );

  // Same-cycle forwarding so decode sees the value being retired this edge.
  assign Dato1 = (commit && ReadReg1 == MUXRes) ? WriteData : raw1;
  assign Dato2 = (commit && ReadReg2 == MUXRes) ? WriteData : raw2;

  always_ff @(posedge clk) begin
    if (reset)
      retire_count_q <= '0;
    else if (commit)
      retire_count_q <= retire_count_q + 32'd1;
  end

  assign RetireCount = retire_count_q;
endmodule
